// File: rtl/gate_vec_gen.sv
// Stimulus generator that steps the four {b,a} combinations of a two-input gate,
// holding each for DWELL_CYCLES clocks. Define GATE_VEC_GRAY_EN for Gray-ordered vectors.
module gate_vec_gen #(
  parameter int DWELL_CYCLES = 10,
  parameter int LOOP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  output logic                  a,
  output logic                  b,
  output logic [1:0]            vec_idx,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [LOOP_CNT_W-1:0] loop_cnt
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Returns {b,a} for a step number.
  function automatic logic [1:0] vec_map(input logic [1:0] idx);
`ifdef GATE_VEC_GRAY_EN
    vec_map = idx ^ {1'b0, idx[1]};
`else
    vec_map = idx;
`endif
  endfunction

  logic [1:0] next_ab;
  assign next_ab = vec_map(vec_idx + 2'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      a        <= 1'b0;
      b        <= 1'b0;
      vec_idx  <= 2'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loop_cnt <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !stop) begin
            state    <= S_RUN;
            vec_idx  <= 2'd0;
            {b, a}   <= vec_map(2'd0);
            valid    <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            loop_cnt <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Abort: no done pulse, loop_cnt keeps the passes completed so far.
            state   <= S_IDLE;
            {b, a}  <= 2'b00;
            vec_idx <= 2'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (vec_idx != 2'd3) begin
              vec_idx <= vec_idx + 2'd1;
              {b, a}  <= next_ab;
            end else if (loop) begin
              vec_idx <= 2'd0;
              {b, a}  <= vec_map(2'd0);
              if (loop_cnt != '1) loop_cnt <= loop_cnt + 1'b1;
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              valid   <= 1'b0;
              busy    <= 1'b0;
              {b, a}  <= 2'b00;
              vec_idx <= 2'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vec_gen.sv
// Directed bench for gate_vec_gen: three instances with dwell 10, 1 and 2 cycles,
// checked with immediate assertions against hand-written vector tables.
module tb_gate_vec_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Expected {b,a} per step, written out by hand for each ordering.
`ifdef GATE_VEC_GRAY_EN
  logic [1:0] ab_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
  logic [1:0] ab_tbl [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Instance with DWELL_CYCLES=10
  logic       s10, p10, l10, a10, b10, v10, y10, d10;
  logic [1:0] i10;
  logic [7:0] c10;
  gate_vec_gen #(.DWELL_CYCLES(10), .LOOP_CNT_W(8)) dut10 (
    .clk(clk), .reset(reset), .start(s10), .stop(p10), .loop(l10),
    .a(a10), .b(b10), .vec_idx(i10), .valid(v10), .busy(y10), .done(d10), .loop_cnt(c10));

  // Instance with DWELL_CYCLES=1
  logic       s1, p1, l1, a1, b1, v1, y1, d1;
  logic [1:0] i1;
  logic [7:0] c1;
  gate_vec_gen #(.DWELL_CYCLES(1), .LOOP_CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .stop(p1), .loop(l1),
    .a(a1), .b(b1), .vec_idx(i1), .valid(v1), .busy(y1), .done(d1), .loop_cnt(c1));

  // Instance with DWELL_CYCLES=2
  logic       s2, p2, l2, a2, b2, v2, y2, d2;
  logic [1:0] i2;
  logic [7:0] c2;
  gate_vec_gen #(.DWELL_CYCLES(2), .LOOP_CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(s2), .stop(p2), .loop(l2),
    .a(a2), .b(b2), .vec_idx(i2), .valid(v2), .busy(y2), .done(d2), .loop_cnt(c2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle10(input string tag);
    check({tag, ".ab"},    32'({b10, a10}), 32'd0);
    check({tag, ".idx"},   32'(i10), 32'd0);
    check({tag, ".valid"}, 32'(v10), 32'd0);
    check({tag, ".busy"},  32'(y10), 32'd0);
    check({tag, ".done"},  32'(d10), 32'd0);
  endtask

  initial begin
    logic [1:0] prev_ab;
    reset = 1'b1;
    {s10, p10, l10} = 3'b000;
    {s1, p1, l1}    = 3'b000;
    {s2, p2, l2}    = 3'b000;
    #12;
    check_idle10("reset");
    check("reset.loop_cnt", 32'(c10), 32'd0);
    reset = 1'b0;
    step();

    // Single pass, dwell 10
    s10 = 1'b1;
    step();
    s10 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("pass.valid%0d", k), 32'(v10), 32'd1);
      check($sformatf("pass.idx%0d", k), 32'(i10), 32'(k / 10));
      check($sformatf("pass.ab%0d", k), 32'({b10, a10}), 32'(ab_tbl[k / 10]));
      check($sformatf("pass.done%0d", k), 32'(d10), 32'd0);
      step();
    end
    check("pass.done_pulse", 32'(d10), 32'd1);
    check("pass.done_valid", 32'(v10), 32'd0);
    check("pass.done_busy", 32'(y10), 32'd0);
    check("pass.done_ab", 32'({b10, a10}), 32'd0);
    step();
    check_idle10("pass.after");

    // Loop mode: three passes then stop
    l10 = 1'b1;
    s10 = 1'b1;
    step();
    s10 = 1'b0;
    check("loop.cnt0", 32'(c10), 32'd0);
    for (int p = 1; p <= 3; p++) begin
      repeat (39) step();
      check($sformatf("loop.idx3_%0d", p), 32'(i10), 32'd3);
      step();
      check($sformatf("loop.wrap_idx%0d", p), 32'(i10), 32'd0);
      check($sformatf("loop.wrap_ab%0d", p), 32'({b10, a10}), 32'(ab_tbl[0]));
      check($sformatf("loop.valid%0d", p), 32'(v10), 32'd1);
      check($sformatf("loop.cnt%0d", p), 32'(c10), 32'(p));
    end
    p10 = 1'b1;
    step();
    p10 = 1'b0;
    l10 = 1'b0;
    check_idle10("loop.stop");
    check("loop.stop_cnt", 32'(c10), 32'd3);
    step();
    check("loop.no_done", 32'(d10), 32'd0);
    check("loop.hold_cnt", 32'(c10), 32'd3);

    // Stop at counter 4 of step 2, then restart
    s10 = 1'b1;
    step();
    s10 = 1'b0;
    check("abort.cnt_clear", 32'(c10), 32'd0);
    repeat (24) step();
    check("abort.idx2", 32'(i10), 32'd2);
    p10 = 1'b1;
    step();
    p10 = 1'b0;
    check_idle10("abort");
    step();
    check("abort.no_done", 32'(d10), 32'd0);
    s10 = 1'b1;
    step();
    s10 = 1'b0;
    check("restart.idx", 32'(i10), 32'd0);
    check("restart.valid", 32'(v10), 32'd1);
    check("restart.busy", 32'(y10), 32'd1);
    check("restart.cnt", 32'(c10), 32'd0);

    // Asynchronous reset in step 1, no clock edge involved
    repeat (15) step();
    check("areset.pre_idx", 32'(i10), 32'd1);
    reset = 1'b1;
    #2;
    check_idle10("areset");
    check("areset.loop_cnt", 32'(c10), 32'd0);
    step();
    reset = 1'b0;
    step();

    // start and stop together in IDLE
    s10 = 1'b1;
    p10 = 1'b1;
    step();
    check_idle10("startstop");
    s10 = 1'b0;
    p10 = 1'b0;
    step();
    check("startstop.busy2", 32'(y10), 32'd0);

    // Dwell 1: new vector every cycle, start pulse during RUN ignored
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d1.valid%0d", k), 32'(v1), 32'd1);
      check($sformatf("d1.idx%0d", k), 32'(i1), 32'(k));
      check($sformatf("d1.ab%0d", k), 32'({b1, a1}), 32'(ab_tbl[k]));
      s1 = (k == 1);
      step();
    end
    s1 = 1'b0;
    check("d1.done", 32'(d1), 32'd1);
    check("d1.valid_off", 32'(v1), 32'd0);
    step();
    check("d1.done_off", 32'(d1), 32'd0);
    check("d1.busy_off", 32'(y1), 32'd0);

    // Dwell 2 in loop mode across the wrap
    l2 = 1'b1;
    s2 = 1'b1;
    step();
    s2 = 1'b0;
    prev_ab = {b2, a2};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("d2.ab%0d", k), 32'({b2, a2}), 32'(ab_tbl[(k / 2) % 4]));
      check($sformatf("d2.valid%0d", k), 32'(v2), 32'd1);
`ifdef GATE_VEC_GRAY_EN
      if (k % 2 == 0 && k > 0)
        check($sformatf("d2.onebit%0d", k), 32'($countones(prev_ab ^ {b2, a2})), 32'd1);
`endif
      prev_ab = {b2, a2};
      step();
    end
    check("d2.loop_cnt", 32'(c2), 32'd1);
    p2 = 1'b1;
    step();
    p2 = 1'b0;
    check("d2.stop_valid", 32'(v2), 32'd0);
    check("d2.stop_done", 32'(d2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
